seq_detect_fsm: RTL



---
 rtl/seq_detect_fsm.sv | 60 ++++++
 1 files changed

// File: rtl/seq_detect_fsm.sv
// rtl/seq_detect_fsm.sv - Moore FSM detecting serial pattern 1011 with a detect pulse and a match counter
module seq_detect_fsm #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  input  logic             ovl,
  output logic             det,
  output logic [CNT_W-1:0] cnt,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_det;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_hit;

  always_comb begin
    w_next = r_state;
    w_hit  = en & d & (r_state == S3);
    case (r_state)
      S0: if (en) w_next = d ? S1 : S0;
      S1: if (en) w_next = d ? S1 : S2;
      S2: if (en) w_next = d ? S3 : S0;
      S3: if (en) w_next = d ? S4 : S2;
      // Overlap keeps the trailing "1" so a following "0" lands in S2.
      S4: if (en) w_next = d ? S1 : (ovl ? S2 : S0);
      default: w_next = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S0;
      r_det   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_det   <= w_hit;
      if (w_hit && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign state = r_state;
  assign det   = r_det;
  assign cnt   = r_cnt;

endmodule
